// File: rtl/track_pkg.sv
// Shared types and defaults for the single-track section arbiter.
package track_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN_EB,
    RUN_WB,
    DRAIN,
    CLEAR,
    FAULT
  } arb_state_t;

  localparam logic DIR_EB = 1'b1;
  localparam logic DIR_WB = 1'b0;

  localparam int DEF_CNT_W        = 4;
  localparam int DEF_MAX_BATCH    = 3;
  localparam int DEF_CLEAR_CYCLES = 8;
  localparam int DEF_TMR_W        = 8;

endpackage

// File: rtl/section_counter.sv
// Saturating up/down count of trains inside the section. The error flags are
// combinational so the arbiter can react on the same edge as the bad pulse.
module section_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf_err,
  output logic             unf_err
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: simultaneous inc/dec cancel, and a bound hit holds the value.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    count_d = count_q;
    ovf_err = 1'b0;
    unf_err = 1'b0;
    if (inc && !dec) begin
      if (count_q == '1) ovf_err = 1'b1;
      else               count_d = count_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count_q == '0) unf_err = 1'b1;
      else               count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/single_track_arbiter.sv
// Grants a single-track section to one direction at a time, counts trains in
// and out, and drains plus clears the section before reversing direction.
module single_track_arbiter
  import track_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MAX_BATCH    = DEF_MAX_BATCH,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int TMR_W        = DEF_TMR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_w,
  input  logic             req_e,
  input  logic             sens_w,
  input  logic             sens_e,
  output logic             sig_w,
  output logic             sig_e,
  output logic             dir_eb,
  output logic             busy,
  output logic [CNT_W-1:0] occupancy,
  output logic             fault
);

  localparam int BATCH_W = (MAX_BATCH < 1) ? 1 : $clog2(MAX_BATCH + 1);
  localparam logic [BATCH_W-1:0] BATCH_MAX = BATCH_W'(MAX_BATCH);

  arb_state_t         state_q, state_d;
  logic [BATCH_W-1:0] batch_q, batch_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               dir_eb_q, dir_eb_d;
  logic               last_dir_q, last_dir_d;
  logic               sig_w_q, sig_w_d;
  logic               sig_e_q, sig_e_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;

  logic entry_pulse, exit_pulse, own_req, other_req, running;
  logic cnt_inc, cnt_dec, ovf_err, unf_err;

  // Map the physical sensors/requests onto the granted direction.
  assign entry_pulse = dir_eb_q ? sens_w : sens_e;
  assign exit_pulse  = dir_eb_q ? sens_e : sens_w;
  assign own_req     = dir_eb_q ? req_w  : req_e;
  assign other_req   = dir_eb_q ? req_e  : req_w;
  assign running     = (state_q == RUN_EB) || (state_q == RUN_WB);

  // Counting is live only while a grant is running or the section drains.
  assign cnt_inc = running & entry_pulse;
  assign cnt_dec = (running || (state_q == DRAIN)) & exit_pulse;

  section_counter #(.CNT_W(CNT_W)) u_counter (
    .clk     (clk),
    .reset   (reset),
    .inc     (cnt_inc),
    .dec     (cnt_dec),
    .count   (occupancy),
    .ovf_err (ovf_err),
    .unf_err (unf_err)
  );

  // Next-state, batch/timer/direction updates and registered-output values.
  always_comb begin
    state_d    = state_q;
    batch_d    = batch_q;
    timer_d    = timer_q;
    dir_eb_d   = dir_eb_q;
    last_dir_d = last_dir_q;

    unique case (state_q)
      IDLE: begin
        if (sens_w || sens_e) begin
          state_d = FAULT;
        end else if (req_w && (!req_e || last_dir_q == DIR_WB)) begin
          state_d  = RUN_EB;
          dir_eb_d = DIR_EB;
          batch_d  = '0;
        end else if (req_e) begin
          state_d  = RUN_WB;
          dir_eb_d = DIR_WB;
          batch_d  = '0;
        end
      end
      RUN_EB, RUN_WB: begin
        if (entry_pulse && batch_q != BATCH_MAX) batch_d = batch_q + BATCH_W'(1);
        if (ovf_err || unf_err)                          state_d = FAULT;
        else if (!own_req || (batch_d == BATCH_MAX && other_req)) state_d = DRAIN;
      end
      DRAIN: begin
        if (entry_pulse || unf_err) begin
          state_d = FAULT;
        end else if (occupancy == '0) begin
          timer_d = TMR_W'(CLEAR_CYCLES);
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (sens_w || sens_e) begin
          state_d = FAULT;
        end else if (timer_q <= TMR_W'(1)) begin
          timer_d    = '0;
          last_dir_d = dir_eb_q;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    sig_w_d = (state_d == RUN_EB);
    sig_e_d = (state_d == RUN_WB);
    busy_d  = (state_d != IDLE);
    fault_d = (state_d == FAULT);
  end

  // State and output registers; reset aborts straight to the idle values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      batch_q    <= '0;
      timer_q    <= '0;
      dir_eb_q   <= 1'b0;
      last_dir_q <= DIR_WB;
      sig_w_q    <= 1'b0;
      sig_e_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      batch_q    <= batch_d;
      timer_q    <= timer_d;
      dir_eb_q   <= dir_eb_d;
      last_dir_q <= last_dir_d;
      sig_w_q    <= sig_w_d;
      sig_e_q    <= sig_e_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign sig_w  = sig_w_q;
  assign sig_e  = sig_e_q;
  assign dir_eb = dir_eb_q;
  assign busy   = busy_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_single_track_arbiter.sv
// Directed bench for single_track_arbiter: a default-size instance for the
// traffic scenarios and a 2-bit-counter instance for the overflow bound.
module tb_single_track_arbiter;

  logic       clk;
  logic       reset;
  logic       req_w, req_e, sens_w, sens_e;
  logic       sig_w, sig_e, dir_eb, busy, fault;
  logic [3:0] occupancy;

  logic       s_req_w, s_req_e, s_sens_w, s_sens_e;
  logic       s_sig_w, s_sig_e, s_dir_eb, s_busy, s_fault;
  logic [1:0] s_occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  single_track_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_w     (req_w),
    .req_e     (req_e),
    .sens_w    (sens_w),
    .sens_e    (sens_e),
    .sig_w     (sig_w),
    .sig_e     (sig_e),
    .dir_eb    (dir_eb),
    .busy      (busy),
    .occupancy (occupancy),
    .fault     (fault)
  );

  single_track_arbiter #(.CNT_W(2)) dut_small (
    .clk       (clk),
    .reset     (reset),
    .req_w     (s_req_w),
    .req_e     (s_req_e),
    .sens_w    (s_sens_w),
    .sens_e    (s_sens_e),
    .sig_w     (s_sig_w),
    .sig_e     (s_sig_e),
    .dir_eb    (s_dir_eb),
    .busy      (s_busy),
    .occupancy (s_occupancy),
    .fault     (s_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic w, input logic e);
    sens_w = w;
    sens_e = e;
    tick(1);
    sens_w = 1'b0;
    sens_e = 1'b0;
  endtask

  task automatic s_pulse_w();
    s_sens_w = 1'b1;
    tick(1);
    s_sens_w = 1'b0;
  endtask

  // Assert reset between edges, confirm the outputs clear with no clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_sig_w"}, sig_w, 0);
    check({tag, "_sig_e"}, sig_e, 0);
    check({tag, "_occ"},   occupancy, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_dir"},   dir_eb, 0);
    req_w = 0; req_e = 0; sens_w = 0; sens_e = 0;
    s_req_w = 0; s_req_e = 0; s_sens_w = 0; s_sens_e = 0;
    tick(1);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    req_w = 0; req_e = 0; sens_w = 0; sens_e = 0;
    s_req_w = 0; s_req_e = 0; s_sens_w = 0; s_sens_e = 0;
    #1 reset = 1'b0;
    #1;
    check("rst_sig_w", sig_w, 0);
    check("rst_sig_e", sig_e, 0);
    check("rst_occ",   occupancy, 0);
    check("rst_fault", fault, 0);
    check("rst_busy",  busy, 0);
    check("rst_dir",   dir_eb, 0);
    tick(2);
    reset = 1'b1;

    // Basic eastbound pass.
    req_w = 1;
    tick(1);
    check("eb_grant_sig_w", sig_w, 1);
    check("eb_grant_sig_e", sig_e, 0);
    check("eb_grant_dir",   dir_eb, 1);
    check("eb_grant_busy",  busy, 1);
    pulse(1, 0);
    check("eb_enter_occ", occupancy, 1);
    req_w = 0;
    tick(1);
    check("eb_drain_sig_w", sig_w, 0);
    check("eb_drain_busy",  busy, 1);
    pulse(0, 1);
    check("eb_exit_occ", occupancy, 0);
    tick(8);
    check("eb_clear_busy", busy, 1);
    tick(1);
    check("eb_idle_busy", busy, 0);
    check("eb_idle_dir",  dir_eb, 1);
    // Both requesting after an EB grant: westbound wins.
    req_w = 1; req_e = 1;
    tick(1);
    check("alt_sig_e", sig_e, 1);
    check("alt_sig_w", sig_w, 0);
    check("alt_dir",   dir_eb, 0);
    do_reset("rst1");

    // Contention: EB first, batch of 3 entries ends the grant at once.
    req_w = 1; req_e = 1;
    tick(1);
    check("ct_sig_w", sig_w, 1);
    check("ct_sig_e", sig_e, 0);
    pulse(1, 0);
    pulse(1, 0);
    check("ct_batch2_sig_w", sig_w, 1);
    pulse(1, 0);
    check("ct_batch3_sig_w", sig_w, 0);
    check("ct_batch3_occ",   occupancy, 3);
    pulse(0, 1);
    pulse(0, 1);
    pulse(0, 1);
    check("ct_empty_occ", occupancy, 0);
    tick(9);
    check("ct_idle_busy", busy, 0);
    check("ct_idle_sig_e", sig_e, 0);
    tick(1);
    check("ct_wb_sig_e", sig_e, 1);
    check("ct_wb_dir",   dir_eb, 0);
    check("ct_wb_sig_w", sig_w, 0);
    do_reset("rst2");

    // Simultaneous entry and exit at occupancy 2.
    req_w = 1;
    tick(1);
    pulse(1, 0);
    pulse(1, 0);
    check("sim_pre_occ", occupancy, 2);
    pulse(1, 1);
    check("sim_occ",   occupancy, 2);
    check("sim_fault", fault, 0);
    check("sim_sig_w", sig_w, 1);
    // Batch is now 3, so a WB request ends the grant immediately.
    req_e = 1;
    tick(1);
    check("sim_batch_drain_sig_w", sig_w, 0);
    check("sim_batch_drain_busy",  busy, 1);

    // Train passes the red west signal during DRAIN.
    pulse(1, 0);
    check("red_drain_fault", fault, 1);
    check("red_drain_sig_w", sig_w, 0);
    check("red_drain_sig_e", sig_e, 0);
    check("red_drain_occ",   occupancy, 2);
    tick(3);
    check("red_hold_fault", fault, 1);
    check("red_hold_sig_e", sig_e, 0);
    check("red_hold_occ",   occupancy, 2);
    do_reset("rst3");

    // Any pulse during CLEAR.
    req_w = 1;
    tick(1);
    req_w = 0;
    tick(3);
    check("clr_pre_fault", fault, 0);
    check("clr_pre_busy",  busy, 1);
    pulse(0, 1);
    check("clr_fault", fault, 1);
    check("clr_sig_w", sig_w, 0);
    do_reset("rst4");

    // Exit at occupancy 0 during a WB grant.
    req_e = 1;
    tick(1);
    check("unf_sig_e", sig_e, 1);
    pulse(1, 0);
    check("unf_fault", fault, 1);
    check("unf_occ",   occupancy, 0);
    check("unf_sig_e_off", sig_e, 0);
    do_reset("rst5");

    // Async reset mid-run with two trains in the section.
    req_w = 1;
    tick(1);
    pulse(1, 0);
    pulse(1, 0);
    check("ar_pre_occ", occupancy, 2);
    do_reset("ar");
    tick(1);
    check("ar_post_busy",  busy, 0);
    check("ar_post_sig_w", sig_w, 0);

    // Overflow on the 2-bit instance.
    s_req_w = 1;
    tick(1);
    check("ovf_sig_w", s_sig_w, 1);
    s_pulse_w();
    s_pulse_w();
    s_pulse_w();
    check("ovf_full_occ",   s_occupancy, 3);
    check("ovf_full_fault", s_fault, 0);
    s_pulse_w();
    check("ovf_occ",   s_occupancy, 3);
    check("ovf_fault", s_fault, 1);
    check("ovf_sig_w_off", s_sig_w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
